// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEC_W   = 13;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t        SEC_TENS_MAX = 4'd5;
  localparam bcd_t        DIGIT_MAX    = 4'd9;
  localparam int unsigned T_MAX        = 5999;

  // Four BCD digits, most significant (minutes tens) first.
  typedef struct packed {
    bcd_t m10;
    bcd_t m1;
    bcd_t s10;
    bcd_t s1;
  } mmss_t;

  function automatic logic [SEC_W-1:0] to_seconds(input mmss_t t);
    return SEC_W'(t.m10) * SEC_W'(600) + SEC_W'(t.m1) * SEC_W'(60)
         + SEC_W'(t.s10) * SEC_W'(10) + SEC_W'(t.s1);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the add/borrow chain: digit + add + carry_in - borrow_in,
// wrapped into 0..max_i with a single carry or borrow out.
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic [3:0] max_i,
  input  logic [3:0] add_i,
  input  logic       carry_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  localparam int unsigned SUM_W = 5;

  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] net_c;

  always_comb begin
    sum_c    = SUM_W'(digit_i) + SUM_W'(add_i) + SUM_W'(carry_i);
    net_c    = sum_c - SUM_W'(borrow_i);
    digit_o  = '0;
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    if (borrow_i && (sum_c == '0)) begin
      digit_o  = max_i;
      borrow_o = 1'b1;
    end else if (net_c > SUM_W'(max_i)) begin
      // Sum never exceeds 2*max+1, so one wrap is always enough.
      digit_o = DIGIT_W'(net_c - SUM_W'(max_i) - SUM_W'(1));
      carry_o = 1'b1;
    end else begin
      digit_o = DIGIT_W'(net_c);
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Four-digit BCD race countdown (MM:SS) with bonus-time additions,
// saturation at 99:59, sticky expiry and a low-time warning.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter logic [3:0]  INIT_M10  = 4'h0,
  parameter logic [3:0]  INIT_M1   = 4'h1,
  parameter logic [3:0]  INIT_S10  = 4'h3,
  parameter logic [3:0]  INIT_S1   = 4'h0,
  parameter int unsigned BONUS_SEC = 10,
  parameter int unsigned LOW_SEC   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       tick,
  input  logic       bonus,
  output logic [3:0] count1,
  output logic [3:0] count2,
  output logic [3:0] count3,
  output logic [3:0] count4,
  output logic       low_time,
  output logic       expired,
  output logic       expired_pulse
);

  localparam bcd_t  BONUS_S1  = DIGIT_W'(BONUS_SEC % 10);
  localparam bcd_t  BONUS_S10 = DIGIT_W'(BONUS_SEC / 10);
  localparam mmss_t INIT_T    = {INIT_M10, INIT_M1, INIT_S10, INIT_S1};
  localparam mmss_t SAT_T     = {DIGIT_MAX, DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX};

  mmss_t            time_q, time_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;
  logic             low_q, low_d;

  mmss_t            base_c, step_c;
  logic [SEC_W-1:0] secs_c, secs_next_c;
  logic [SEC_W:0]   sum_c;
  logic             dec_c, add_c, sat_c;
  bcd_t             add_s1_c, add_s10_c;
  bcd_t             s1_nxt, s10_nxt, m1_nxt, m10_nxt;
  logic             c1, c2, c3, c4, b1, b2, b3, b4;

  // Event qualification and saturation-before-decrement selection.
  always_comb begin
    secs_c    = to_seconds(time_q);
    dec_c     = tick & run & (secs_c != '0) & ~expired_q;
    add_c     = bonus & ~expired_q;
    sum_c     = (SEC_W+1)'(secs_c) + (SEC_W+1)'(BONUS_SEC);
    sat_c     = add_c && (sum_c > (SEC_W+1)'(T_MAX));
    base_c    = sat_c ? SAT_T : time_q;
    add_s1_c  = (add_c && !sat_c) ? BONUS_S1  : '0;
    add_s10_c = (add_c && !sat_c) ? BONUS_S10 : '0;
  end

  bcd_digit_step u_s1 (
    .digit_i (base_c.s1), .max_i (DIGIT_MAX), .add_i (add_s1_c),
    .carry_i (1'b0), .borrow_i (dec_c),
    .digit_o (s1_nxt), .carry_o (c1), .borrow_o (b1)
  );

  bcd_digit_step u_s10 (
    .digit_i (base_c.s10), .max_i (SEC_TENS_MAX), .add_i (add_s10_c),
    .carry_i (c1), .borrow_i (b1),
    .digit_o (s10_nxt), .carry_o (c2), .borrow_o (b2)
  );

  bcd_digit_step u_m1 (
    .digit_i (base_c.m1), .max_i (DIGIT_MAX), .add_i (4'd0),
    .carry_i (c2), .borrow_i (b2),
    .digit_o (m1_nxt), .carry_o (c3), .borrow_o (b3)
  );

  bcd_digit_step u_m10 (
    .digit_i (base_c.m10), .max_i (DIGIT_MAX), .add_i (4'd0),
    .carry_i (c3), .borrow_i (b3),
    .digit_o (m10_nxt), .carry_o (c4), .borrow_o (b4)
  );

  assign step_c = {m10_nxt, m1_nxt, s10_nxt, s1_nxt};

  // Next state: load wins; the chain result is only taken if it stayed in range.
  always_comb begin
    time_d    = time_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;
    if (load) begin
      time_d    = INIT_T;
      expired_d = 1'b0;
    end else if (!(c4 | b4)) begin
      time_d = step_c;
      if (dec_c && (step_c == '0)) begin
        expired_d = 1'b1;
        pulse_d   = 1'b1;
      end
    end
    secs_next_c = to_seconds(time_d);
    low_d       = (secs_next_c != '0) && (secs_next_c <= SEC_W'(LOW_SEC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q    <= '0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      low_q     <= 1'b0;
    end else begin
      time_q    <= time_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      low_q     <= low_d;
    end
  end

  assign count1        = time_q.s1;
  assign count2        = time_q.s10;
  assign count3        = time_q.m1;
  assign count4        = time_q.m10;
  assign low_time      = low_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer with default parameters (INIT 01:30, bonus 10 s, low 10 s).
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       reset, load, run, tick, bonus;
  logic [3:0] count1, count2, count3, count4;
  logic       low_time, expired, expired_pulse;
  logic [15:0] digits;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_down_timer dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .run           (run),
    .tick          (tick),
    .bonus         (bonus),
    .count1        (count1),
    .count2        (count2),
    .count3        (count3),
    .count4        (count4),
    .low_time      (low_time),
    .expired       (expired),
    .expired_pulse (expired_pulse)
  );

  always #5 clk = ~clk;

  assign digits = {count4, count3, count2, count1};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    cycles(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; run = 1'b0; tick = 1'b0; bonus = 1'b0;
    cycles(2);
    chk("rst_digits",  digits, 16'h0000);
    chk("rst_expired", 16'(expired), 16'd0);
    chk("rst_pulse",   16'(expired_pulse), 16'd0);
    chk("rst_low",     16'(low_time), 16'd0);
    reset = 1'b0;

    // Idle at 00:00 before any load: ticks ignored, no expiry.
    run = 1'b1; tick = 1'b1;
    cycles(3);
    tick = 1'b0;
    chk("idle_digits",  digits, 16'h0000);
    chk("idle_expired", 16'(expired), 16'd0);

    do_load();
    chk("load_digits",  digits, 16'h0130);
    chk("load_expired", 16'(expired), 16'd0);
    chk("load_low",     16'(low_time), 16'd0);

    // Count down to the low-time boundary.
    tick = 1'b1;
    cycles(79);
    chk("cnt_0011",     digits, 16'h0011);
    chk("low_at_11",    16'(low_time), 16'd0);
    cycles(1);
    chk("cnt_0010",     digits, 16'h0010);
    chk("low_at_10",    16'(low_time), 16'd1);
    cycles(8);
    chk("cnt_0002",     digits, 16'h0002);
    cycles(1);
    chk("cnt_0001",     digits, 16'h0001);
    chk("pre_exp",      16'(expired), 16'd0);
    chk("pre_pulse",    16'(expired_pulse), 16'd0);
    cycles(1);
    chk("exp_digits",   digits, 16'h0000);
    chk("exp_set",      16'(expired), 16'd1);
    chk("exp_pulse",    16'(expired_pulse), 16'd1);
    chk("exp_low",      16'(low_time), 16'd0);
    tick = 1'b0;
    cycles(1);
    chk("pulse_drop",   16'(expired_pulse), 16'd0);
    chk("exp_sticky",   16'(expired), 16'd1);
    tick = 1'b1; bonus = 1'b1;
    cycles(3);
    tick = 1'b0; bonus = 1'b0;
    chk("exp_ignore",   digits, 16'h0000);
    chk("exp_hold",     16'(expired), 16'd1);
    chk("exp_nopulse",  16'(expired_pulse), 16'd0);
    do_load();
    chk("reload",       digits, 16'h0130);
    chk("reload_exp",   16'(expired), 16'd0);

    // Bonus carries up to 10:00, then one tick borrows through every digit.
    bonus = 1'b1;
    cycles(51);
    bonus = 1'b0;
    chk("carry_1000",   digits, 16'h1000);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    chk("borrow_0959",  digits, 16'h0959);

    do_load();
    tick = 1'b1;
    cycles(35);
    tick = 1'b0;
    chk("cnt_0055",     digits, 16'h0055);
    bonus = 1'b1;
    cycles(1);
    bonus = 1'b0;
    chk("bonus_0105",   digits, 16'h0105);
    tick = 1'b1;
    cycles(10);
    chk("back_0055",    digits, 16'h0055);
    bonus = 1'b1;
    cycles(1);
    bonus = 1'b0; tick = 1'b0;
    chk("bonus_tick",   digits, 16'h0104);
    run = 1'b0; bonus = 1'b1;
    cycles(1);
    bonus = 1'b0;
    chk("bonus_paused", digits, 16'h0114);
    tick = 1'b1;
    cycles(5);
    tick = 1'b0;
    chk("paused_ticks", digits, 16'h0114);
    run = 1'b1;

    // Saturation at 99:59.
    do_load();
    bonus = 1'b1;
    cycles(590);
    chk("bonus_9950",   digits, 16'h9950);
    cycles(1);
    bonus = 1'b0;
    chk("sat_9959",     digits, 16'h9959);
    tick = 1'b1;
    cycles(4);
    tick = 1'b0;
    chk("cnt_9955",     digits, 16'h9955);
    bonus = 1'b1;
    cycles(1);
    bonus = 1'b0;
    chk("sat_bonus",    digits, 16'h9959);
    tick = 1'b1;
    cycles(4);
    chk("cnt_9955b",    digits, 16'h9955);
    bonus = 1'b1;
    cycles(1);
    bonus = 1'b0; tick = 1'b0;
    chk("sat_bonus_tick", digits, 16'h9958);

    // Load beats simultaneous tick and bonus.
    load = 1'b1; tick = 1'b1; bonus = 1'b1;
    cycles(1);
    load = 1'b0; bonus = 1'b0;
    chk("load_prio",    digits, 16'h0130);
    cycles(2);
    chk("cnt_0128",     digits, 16'h0128);

    // Asynchronous reset mid-count, checked between clock edges.
    reset = 1'b1;
    #1;
    chk("async_digits", digits, 16'h0000);
    chk("async_exp",    16'(expired), 16'd0);
    chk("async_pulse",  16'(expired_pulse), 16'd0);
    chk("async_low",    16'(low_time), 16'd0);
    tick = 1'b0;
    cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
